// File: rtl/mmio_bus_unit.sv
// mmio_bus_unit: CPU bus decoder passing RAM accesses through and hosting
// UART transmit, GPIO and a reloading timer in the top eight words of the map.
module mmio_bus_unit #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] address,
    input  logic [15:0] data_out,
    input  logic        memwt,
    output logic [15:0] data_in,
    output logic [11:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    input  logic [15:0] ram_rdata,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out,
    output logic        uart_tx,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
    localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

    uart_state_e state_q, state_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d, bit_idx_nxt;
    logic        tx_q, tx_d;
    logic [7:0]  txdata_q, txdata_d;
    logic [15:0] gpio_out_q, sync1_q, sync2_q;
    logic [15:0] tcnt_q, tcnt_d, treload_q;
    logic        en_q, irqen_q, exp_q, exp_d;
    logic [15:0] mmio_rdata;
    logic        is_mmio, mmio_wr, wr_tx, wr_gpio, wr_tcnt, wr_tctrl, wr_treload;
    logic        busy, tx_accept, bit_done, tmr_hit;

    assign is_mmio    = &address[11:3];
    assign mmio_wr    = memwt && is_mmio;
    assign wr_tx      = mmio_wr && address[2:0] == 3'd0;
    assign wr_gpio    = mmio_wr && address[2:0] == 3'd2;
    assign wr_tcnt    = mmio_wr && address[2:0] == 3'd4;
    assign wr_tctrl   = mmio_wr && address[2:0] == 3'd5;
    assign wr_treload = mmio_wr && address[2:0] == 3'd6;

    assign ram_addr  = address;
    assign ram_wdata = data_out;
    assign ram_we    = memwt && !is_mmio;
    assign data_in   = is_mmio ? mmio_rdata : ram_rdata;
    assign gpio_out  = gpio_out_q;
    assign uart_tx   = tx_q;
    assign irq       = exp_q && irqen_q;

    assign busy        = state_q != IDLE;
    assign tx_accept   = wr_tx && !busy;
    assign bit_done    = clk_cnt_q == LAST_CLK;
    assign bit_idx_nxt = bit_idx_q + 3'd1;

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        txdata_d  = tx_accept ? data_out[7:0] : txdata_q;
        clk_cnt_d = (state_q == IDLE || bit_done) ? 16'd0 : clk_cnt_q + 16'd1;
        case (state_q)
            IDLE: begin
                tx_d    = !tx_accept;
                state_d = tx_accept ? START : IDLE;
            end
            START: if (bit_done) begin
                state_d   = DATA;
                bit_idx_d = 3'd0;
                tx_d      = txdata_q[0];
            end
            DATA: if (bit_done) begin
                state_d   = bit_idx_q == 3'd7 ? STOP : DATA;
                bit_idx_d = bit_idx_nxt;
                tx_d      = bit_idx_q == 3'd7 ? 1'b1 : txdata_q[bit_idx_nxt];
            end
            STOP: if (bit_done) begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // A CPU write to TCNT overrides the timer step; an expiry beats a clear.
    always_comb begin
        tmr_hit = en_q && tcnt_q == 16'd0;
        tcnt_d  = wr_tcnt ? data_out : !en_q ? tcnt_q : tmr_hit ? treload_q : tcnt_q - 16'd1;
        exp_d   = tmr_hit || (exp_q && !(wr_tctrl && data_out[1]));
    end

    always_comb begin
        mmio_rdata = 16'h0000;
        case (address[2:0])
            3'd0: mmio_rdata = {8'h00, txdata_q};
            3'd1: mmio_rdata = {15'b0, busy};
            3'd2: mmio_rdata = gpio_out_q;
            3'd3: mmio_rdata = sync2_q;
            3'd4: mmio_rdata = tcnt_q;
            3'd5: mmio_rdata = {13'b0, irqen_q, exp_q, en_q};
            3'd6: mmio_rdata = treload_q;
            default: mmio_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            clk_cnt_q  <= 16'd0;
            bit_idx_q  <= 3'd0;
            tx_q       <= 1'b1;
            txdata_q   <= 8'h00;
            gpio_out_q <= 16'h0000;
            sync1_q    <= 16'h0000;
            sync2_q    <= 16'h0000;
            tcnt_q     <= 16'h0000;
            treload_q  <= 16'h0000;
            en_q       <= 1'b0;
            irqen_q    <= 1'b0;
            exp_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            txdata_q   <= txdata_d;
            gpio_out_q <= wr_gpio ? data_out : gpio_out_q;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            tcnt_q     <= tcnt_d;
            treload_q  <= wr_treload ? data_out : treload_q;
            en_q       <= wr_tctrl ? data_out[0] : en_q;
            irqen_q    <= wr_tctrl ? data_out[2] : irqen_q;
            exp_q      <= exp_d;
        end
    end
endmodule

// File: doc/mmio_bus_unit.md
MMIO_BUS_UNIT -- requirements
Module: mmio_bus_unit

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per UART bit period (legal range 2..65535).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 address  input  12  CPU memory address.
REQ-005 data_out  input  16  CPU write data.
REQ-006 memwt  input  1  CPU write strobe, active high, one cycle per write.
REQ-007 data_in  output  16  read data to CPU, combinational from address.
REQ-008 ram_addr  output  12  RAM address, equal to address.
REQ-009 ram_wdata  output  16  RAM write data, equal to data_out.
REQ-010 ram_we  output  1  RAM write enable.
REQ-011 ram_rdata  input  16  RAM asynchronous read data.
REQ-012 gpio_in  input  16  asynchronous external inputs.
REQ-013 gpio_out  output  16  registered GPIO outputs.
REQ-014 uart_tx  output  1  serial 8N1 transmit line, idle high.
REQ-015 irq  output  1  timer interrupt, level.

Function
REQ-016 Decode: address < 12'hFF8 is RAM; 12'hFF8..12'hFFF is MMIO.
REQ-017 ram_we = memwt AND RAM region; MMIO writes never reach RAM.
REQ-018 data_in = ram_rdata for RAM region, else MMIO read mux; zero-cycle latency, no registered read path.
REQ-019 MMIO map, read/write: FF8 TXDATA; FF9 STATUS; FFA GPIO_OUT; FFB GPIO_IN; FFC TCNT; FFD TCTRL; FFE TRELOAD; FFF reserved.
REQ-020 TXDATA write with busy=0: latch data_out[7:0], start frame; write with busy=1 ignored; read {8'h00, last accepted byte}.
REQ-021 STATUS read {15'b0, busy}; writes ignored.
REQ-022 GPIO_OUT read/write 16 bits, drives gpio_out directly.
REQ-023 GPIO_IN read = gpio_in after two-flop synchronizer (2-cycle latency); writes ignored.
REQ-024 FFF reads 16'h0000; writes ignored.
REQ-025 UART FSM states IDLE, START, DATA, STOP; each bit held exactly CLKS_PER_BIT cycles.
REQ-026 Accepted write: next edge enters START, uart_tx=0, busy=1.
REQ-027 DATA sends 8 bits LSB first via 3-bit bit index; STOP drives 1; after STOP, return to IDLE with busy=0 -- frame = 10*CLKS_PER_BIT cycles.
REQ-028 uart_tx is registered (glitch-free); 1 in IDLE.
REQ-029 TCTRL bits: [0] enable, [1] expired (sticky), [2] irq_en; read {13'b0, irq_en, expired, enable}.
REQ-030 TCTRL write: loads enable, irq_en; data_out[1]=1 clears expired, 0 leaves it.
REQ-031 Timer, enable=1: TCNT==0 -> TCNT<=TRELOAD, expired<=1; else TCNT<=TCNT-1; enable=0 holds TCNT.
REQ-032 CPU write to TCNT in same cycle as decrement/reload: written value wins.
REQ-033 Expired set and clear in same cycle: set wins.
REQ-034 irq = expired AND irq_en, registered-source, no extra delay.
REQ-035 TCNT, TRELOAD 16-bit unsigned; decrement never underflows (reload at 0).

Reset
REQ-036 rst_n=0 asynchronously: UART IDLE, uart_tx=1, busy=0, TXDATA=0, gpio_out=0, synchronizer=0, TCNT=0, TRELOAD=0, TCTRL=0, irq=0.
REQ-037 Reset mid-frame aborts immediately; uart_tx=1 while rst_n=0; first edge after release samples in IDLE.
REQ-038 ram_we, data_in stay combinational during reset (no gating).

Verification
REQ-039 Write 16'h1234 to 0x010, read 0x010 -> ram_we=1 that cycle, data_in=16'h1234; write 0xFFA -> ram_we=0.
REQ-040 CLKS_PER_BIT=4, write 16'h00A5 to FF8 -> uart_tx 0 for 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, then 1; STATUS=1 for 40 cycles then 0.
REQ-041 Second FF8 write 16'h00FF during busy -> ignored, frame unchanged, TXDATA read = 16'h00A5.
REQ-042 TRELOAD=3, TCNT=2, TCTRL=5 -> TCNT 2,1,0, reload 3, expired=1, irq=1 on 4th edge after enable; write TCTRL=16'h0007 -> expired=0, irq=0.
REQ-043 gpio_in=16'hBEEF -> FFB reads 16'hBEEF 2 cycles later, not before.
REQ-044 rst_n=0 mid-frame, timer running -> uart_tx=1, irq=0, TCNT=0 immediately; after release, all MMIO reads 0 except STATUS=0.
